// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM APB write sequencer.
package pwm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SLV  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;

  localparam int unsigned REG_FIELD_LSB = 2;
  localparam int unsigned CH_FIELD_LSB  = 4;
  localparam int unsigned REG_W         = 2;
  localparam int unsigned DATA_W        = 32;

endpackage

// File: rtl/pwm_seq_fifo.sv
// Synchronous request FIFO; DEPTH must be a power of two, pointers carry a wrap bit.
module pwm_seq_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/pwm_apb_sequencer.sv
// APB master draining a queue of {channel, register, data} write requests
// into the PWM slave array, with wait-state, PSLVERR and timeout handling.
module pwm_apb_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int unsigned                APB_ADDR_WIDTH = 12,
  parameter int unsigned                PWM_CNT        = 4,
  parameter logic [APB_ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
  parameter int unsigned                FIFO_DEPTH     = 4,
  parameter int unsigned                TIMEOUT_CYC    = 16
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [$clog2(PWM_CNT)-1:0]   req_ch,
  input  logic [1:0]                   req_reg,
  input  logic [31:0]                  req_data,
  output logic                         busy,
  output logic                         err_o,
  output logic [1:0]                   err_code,
  output logic [$clog2(PWM_CNT)-1:0]   err_ch,
  input  logic                         err_clr,
  output logic [APB_ADDR_WIDTH-1:0]    PADDR,
  output logic [31:0]                  PWDATA,
  output logic                         PWRITE,
  output logic                         PSEL,
  output logic                         PENABLE,
  input  logic                         PREADY,
  input  logic                         PSLVERR
);

  localparam int unsigned CH_W  = $clog2(PWM_CNT);
  localparam int unsigned ENT_W = CH_W + REG_W + DATA_W;
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_t                    r_state, w_state_nxt;
  logic                      w_push, w_pop, w_full, w_empty;
  logic [ENT_W-1:0]          w_wdata, w_rdata;
  logic [CH_W-1:0]           w_head_ch;
  logic [REG_W-1:0]          w_head_reg;
  logic [DATA_W-1:0]         w_head_data;
  logic [APB_ADDR_WIDTH-1:0] w_head_addr;
  logic                      r_psel, r_penable, r_pwrite;
  logic                      w_psel_nxt, w_penable_nxt;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_W-1:0]         r_pwdata;
  logic [CH_W-1:0]           r_ch;
  logic [TMO_W-1:0]          r_tmo_cnt, w_tmo_cnt_nxt;
  logic                      w_tmo_hit, w_slv_err, w_tmo_err, w_err_evt;
  logic                      r_err;
  logic [1:0]                r_err_code;
  logic [CH_W-1:0]           r_err_ch;

  assign w_push  = req_valid & ~w_full;
  assign w_wdata = {req_ch, req_reg, req_data};
  assign {w_head_ch, w_head_reg, w_head_data} = w_rdata;
  assign w_head_addr = BASE_ADDR
                     | (APB_ADDR_WIDTH'(w_head_ch)  << CH_FIELD_LSB)
                     | (APB_ADDR_WIDTH'(w_head_reg) << REG_FIELD_LSB);
  assign w_tmo_hit = (TIMEOUT_CYC != 0) &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  pwm_seq_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS: begin
        if (PREADY)         w_state_nxt = w_empty ? IDLE : SETUP;
        else if (w_tmo_hit) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered APB controls plus pop/error strobes.
  always_comb begin
    w_psel_nxt    = 1'b0;
    w_penable_nxt = 1'b0;
    w_pop         = 1'b0;
    w_slv_err     = 1'b0;
    w_tmo_err     = 1'b0;
    w_tmo_cnt_nxt = '0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_psel_nxt = 1'b1;
        end
      end
      SETUP: begin
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          w_slv_err = PSLVERR;
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_psel_nxt = 1'b1;
          end
        end else if (w_tmo_hit) begin
          w_tmo_err = 1'b1;
        end else begin
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b1;
          w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_pwrite  <= w_psel_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
    end
  end

  // Address/data only move on a pop so the bus stays quiet while idle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_ch     <= '0;
    end else if (w_pop) begin
      r_paddr  <= w_head_addr;
      r_pwdata <= w_head_data;
      r_ch     <= w_head_ch;
    end
  end

  assign w_err_evt = w_slv_err | w_tmo_err;

  // First error sticks; a new error beats a simultaneous clear.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_err_ch   <= '0;
    end else if (w_err_evt && (!r_err || err_clr)) begin
      r_err      <= 1'b1;
      r_err_code <= w_tmo_err ? ERR_TMO : ERR_SLV;
      r_err_ch   <= r_ch;
    end else if (err_clr) begin
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_err_ch   <= '0;
    end
  end

  assign req_ready = ~w_full;
  assign busy      = ~w_empty | (r_state != IDLE);
  assign err_o     = r_err;
  assign err_code  = r_err_code;
  assign err_ch    = r_err_ch;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PWRITE    = r_pwrite;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;

endmodule
